// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults, pixel formats and
// the colour-expansion helper for the VGA display core.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int CNT_W = 12;

  typedef enum logic {
    FMT_RGB332,
    FMT_RGB444
  } pix_fmt_e;

  // RGB332 widens by replicating the top bits so full
  // scale maps to 4'hF; RGB444 passes straight through.
  function automatic logic [11:0] expand_rgb(
    input pix_fmt_e    fmt,
    input logic [11:0] d
  );
    logic [11:0] c;
    c = d;
    unique case (fmt)
      FMT_RGB332: c = {d[7:5], d[7],
                       d[4:2], d[4],
                       d[1:0], d[1:0]};
      FMT_RGB444: c = d;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: hc/vc raster counters plus registered
// sync/active; *_nxt expose the position about to load.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hc_nxt,
  output logic [CNT_W-1:0] vc_nxt,
  output logic             act_nxt,
  output logic             active,
  output logic             hsync,
  output logic             vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST =
    CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST =
    CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG =
    CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END =
    CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG =
    CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END =
    CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;
  logic             hs_nxt;
  logic             vs_nxt;

  always_comb begin
    hc_nxt = hc + 1'b1;
    vc_nxt = vc;
    if (hc == H_LAST) begin
      hc_nxt = '0;
      vc_nxt = (vc == V_LAST) ? '0 : vc + 1'b1;
    end
    act_nxt = (hc_nxt < H_ACT) && (vc_nxt < V_ACT);
    hs_nxt  = (hc_nxt >= HS_BEG && hc_nxt < HS_END) ?
              SYNC_POL : ~SYNC_POL;
    vs_nxt  = (vc_nxt >= VS_BEG && vc_nxt < VS_END) ?
              SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hc     <= '0;
      vc     <= '0;
      active <= 1'b0;
      hsync  <= ~SYNC_POL;
      vsync  <= ~SYNC_POL;
    end else begin
      hc     <= hc_nxt;
      vc     <= vc_nxt;
      active <= act_nxt;
      hsync  <= hs_nxt;
      vsync  <= vs_nxt;
    end
  end

endmodule

// File: rtl/vga_scaled_display.sv
// vga_scaled_display: scaled ping-pong framebuffer readout,
// vblank bank swap, sync/colour pins (rd_* fetch, rgb out).
module vga_scaled_display
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter bit SYNC_POL   = 1'b0,
  parameter int SCALE_LOG2 = 1,
  parameter int PIX_W      = 8,
  parameter int RD_LAT     = 1,
  parameter int ADDR_W     = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_bank,
  output logic              frame_start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [9:0]        lx,
  output logic [9:0]        ly,
  output logic              hsync,
  output logic              vsync,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue
);

  localparam int LW = H_ACTIVE >> SCALE_LOG2;
  localparam int LH = V_ACTIVE >> SCALE_LOG2;

  localparam logic [ADDR_W-1:0] BANK_SZ = ADDR_W'(LW * LH);
  localparam logic [ADDR_W-1:0] LW_A    = ADDR_W'(LW);
  localparam logic [CNT_W-1:0]  S_MASK  =
    CNT_W'((1 << SCALE_LOG2) - 1);
  localparam logic [CNT_W-1:0]  V_ACT   = CNT_W'(V_ACTIVE);
  localparam pix_fmt_e FMT =
    (PIX_W == 12) ? FMT_RGB444 : FMT_RGB332;

  logic [CNT_W-1:0]  hc_nxt;
  logic [CNT_W-1:0]  vc_nxt;
  logic              act_nxt;
  logic              hs_t;
  logic              vs_t;

  logic              take;
  logic              fb_nxt;
  logic [9:0]        lx_nxt;
  logic [9:0]        ly_nxt;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] row_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [11:0]       rgb;

  logic [RD_LAT:0]   hs_d;
  logic [RD_LAT:0]   vs_d;
  logic [RD_LAT-1:0] act_d;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk     (clk),
    .rst     (rst),
    .hc_nxt  (hc_nxt),
    .vc_nxt  (vc_nxt),
    .act_nxt (act_nxt),
    .active  (rd_en),
    .hsync   (hs_t),
    .vsync   (vs_t)
  );

  // Fetch-side values are computed from the position being
  // loaded so they change on the same edge as the counters.
  // The swap is sampled on the edge entering hc=0, vc=V_ACTIVE.
  always_comb begin
    take   = swap_req && (hc_nxt == '0) && (vc_nxt == V_ACT);
    fb_nxt = front_bank ^ take;
    lx_nxt = 10'(hc_nxt >> SCALE_LOG2);
    ly_nxt = 10'(vc_nxt >> SCALE_LOG2);
    row_nxt = row_base;
    if (vc_nxt == '0)
      row_nxt = '0;
    else if (hc_nxt == '0 && (vc_nxt & S_MASK) == '0)
      row_nxt = row_base + LW_A;
    addr_nxt = '0;
    if (act_nxt)
      addr_nxt = (fb_nxt ? BANK_SZ : '0) + row_nxt +
                 ADDR_W'(lx_nxt);
  end

  assign rgb = expand_rgb(FMT, 12'(rd_data));

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_addr     <= '0;
      lx          <= '0;
      ly          <= '0;
      row_base    <= '0;
      front_bank  <= 1'b0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rd_addr     <= addr_nxt;
      lx          <= lx_nxt;
      ly          <= ly_nxt;
      row_base    <= row_nxt;
      front_bank  <= fb_nxt;
      swap_ack    <= take;
      frame_start <= (hc_nxt == '0) && (vc_nxt == '0);
    end
  end

  // Sync trails the fetch by RD_LAT+1 so it leaves with the
  // colour of the same pixel; act_d gates data arrival.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hs_d  <= {(RD_LAT+1){~SYNC_POL}};
      vs_d  <= {(RD_LAT+1){~SYNC_POL}};
      act_d <= '0;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      hs_d     <= {hs_d[RD_LAT-1:0], hs_t};
      vs_d     <= {vs_d[RD_LAT-1:0], vs_t};
      act_d[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++)
        act_d[i] <= act_d[i-1];
      {red, green, blue} <= act_d[RD_LAT-1] ? rgb : 12'h000;
    end
  end

  assign hsync = hs_d[RD_LAT];
  assign vsync = vs_d[RD_LAT];

endmodule

// File: tb/tb_vga_scaled_display.sv
// tb_vga_scaled_display: randomized scoreboard bench on a
// shrunken raster against an index-based reference model.
module tb_vga_scaled_display;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HSW = 3;
  localparam int HBP = 3;
  localparam int VA  = 8;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 1;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FT  = HT * VT;
  localparam int S   = 1;
  localparam int L   = 2;
  localparam int PW  = 8;
  localparam int AW  = 12;
  localparam bit POL = 1'b0;
  localparam int LW  = HA >> S;
  localparam int LH  = VA >> S;

  logic          clk = 1'b0;
  logic          rst;
  logic          swap_req;
  logic          swap_ack;
  logic          front_bank;
  logic          frame_start;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data;
  logic [9:0]    lx;
  logic [9:0]    ly;
  logic          hsync;
  logic          vsync;
  logic [3:0]    red;
  logic [3:0]    green;
  logic [3:0]    blue;

  always #5 clk = ~clk;

  vga_scaled_display #(
    .H_ACTIVE   (HA),
    .H_FP       (HFP),
    .H_SYNC     (HSW),
    .H_BP       (HBP),
    .V_ACTIVE   (VA),
    .V_FP       (VFP),
    .V_SYNC     (VSW),
    .V_BP       (VBP),
    .SYNC_POL   (POL),
    .SCALE_LOG2 (S),
    .PIX_W      (PW),
    .RD_LAT     (L),
    .ADDR_W     (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .front_bank  (front_bank),
    .frame_start (frame_start),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .lx          (lx),
    .ly          (ly),
    .hsync       (hsync),
    .vsync       (vsync),
    .red         (red),
    .green       (green),
    .blue        (blue)
  );

  typedef struct {
    int idx;
    bit en;
    int addr;
    int lx;
    int ly;
    bit fs;
    bit ack;
    bit fb;
    bit hs;
    bit vs;
    int rgb;
    bit lit;
  } exp_t;

  exp_t eq[$];
  int   checks = 0;
  int   errors = 0;
  logic [PW-1:0] mem [64];
  int   hist[$];
  int   k = 0;
  bit   fb_m = 1'b0;
  bit   m_act[int];
  int   m_addr[int];
  bit   m_hs[int];
  bit   m_vs[int];
  bit   started = 1'b0;
  bit   done = 1'b0;

  // Bit replication written as arithmetic on the fields.
  function automatic int expand(input int d);
    int r3, g3, b2;
    r3 = (d >> 5) & 7;
    g3 = (d >> 2) & 7;
    b2 = d & 3;
    return (r3 * 2 + (r3 >> 2)) * 256 +
           (g3 * 2 + (g3 >> 2)) * 16 + b2 * 5;
  endfunction

  task automatic drive(input bit r, input bit s);
    exp_t e;
    int hc, vc, q;
    @(negedge clk);
    hist.push_back(int'(rd_addr));
    if (hist.size() > L + 1) void'(hist.pop_front());
    if (hist.size() == L + 1) rd_data = mem[hist[0] % 64];
    rst = r;
    swap_req = s;
    e = '{default: 0};
    if (!r) begin
      k = 0;
      fb_m = 1'b0;
      m_act.delete();
      m_addr.delete();
      m_hs.delete();
      m_vs.delete();
      e.hs = !POL;
      e.vs = !POL;
    end else begin
      k++;
      hc = k % HT;
      vc = (k / HT) % VT;
      e.ack = (hc == 0) && (vc == VA) && s;
      if (e.ack) fb_m = !fb_m;
      e.fb = fb_m;
      e.en = (hc < HA) && (vc < VA);
      e.addr = e.en ?
        int'(fb_m) * LW * LH + (vc >> S) * LW + (hc >> S) : 0;
      e.lx = hc >> S;
      e.ly = vc >> S;
      e.fs = (hc == 0) && (vc == 0);
      m_act[k]  = e.en;
      m_addr[k] = e.addr;
      m_hs[k] = (hc >= HA + HFP && hc < HA + HFP + HSW) ?
                POL : !POL;
      m_vs[k] = (vc >= VA + VFP && vc < VA + VFP + VSW) ?
                POL : !POL;
      q = k - (L + 1);
      if (q > 0) begin
        e.hs  = m_hs[q];
        e.vs  = m_vs[q];
        e.rgb = m_act[q] ? expand(int'(mem[m_addr[q]])) : 0;
        e.lit = m_act[q] && (m_addr[q] == 1);
      end else begin
        e.hs = !POL;
        e.vs = !POL;
      end
    end
    e.idx = k;
    eq.push_back(e);
    started = 1'b1;
  endtask

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      int kn, hc, vc;
      bit s;
      kn = k + 1;
      hc = kn % HT;
      vc = (kn / HT) % VT;
      case (mode)
        0:       s = 1'b0;
        1:       s = 1'b1;
        2:       s = (vc == 3);
        3:       s = (hc == 0) && (vc == VA);
        default: s = ($urandom_range(0, 3) == 0);
      endcase
      drive(1'b1, s);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started && !done) begin
        if (eq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL queue_underflow got empty want entry");
        end else begin
          e = eq.pop_front();
          checks++;
          if (rd_en !== e.en || int'(rd_addr) != e.addr ||
              int'(lx) != e.lx || int'(ly) != e.ly ||
              frame_start !== e.fs || swap_ack !== e.ack ||
              front_bank !== e.fb) begin
            errors++;
            $display({"FAIL fetch k=%0d got en%0b a%0d lx%0d",
                      " ly%0d fs%0b ack%0b fb%0b want en%0b",
                      " a%0d lx%0d ly%0d fs%0b ack%0b fb%0b"},
                     e.idx, rd_en, rd_addr, lx, ly,
                     frame_start, swap_ack, front_bank,
                     e.en, e.addr, e.lx, e.ly, e.fs, e.ack,
                     e.fb);
          end
          checks++;
          if (hsync !== e.hs || vsync !== e.vs ||
              int'({red, green, blue}) != e.rgb) begin
            errors++;
            $display({"FAIL pins k=%0d got hs%0b vs%0b rgb%h",
                      " want hs%0b vs%0b rgb%h"},
                     e.idx, hsync, vsync, {red, green, blue},
                     e.hs, e.vs, e.rgb[11:0]);
          end
          if (e.lit) begin
            checks++;
            if ({red, green, blue} !== 12'hB6A) begin
              errors++;
              $display("FAIL rgb332_lit got %h want b6a",
                       {red, green, blue});
            end
          end
        end
      end
    end
  end

  initial begin : stim
    int guard;
    rst = 1'b0;
    swap_req = 1'b0;
    rd_data = '0;
    foreach (mem[i]) mem[i] = PW'($urandom);
    mem[1] = 8'b101_011_10;
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    run(2 * FT, 0);
    run(3 * FT, 1);
    run(2 * FT, 2);
    run(2 * FT, 3);
    guard = 0;
    while (!(((k + 1) % HT) == 10 &&
             (((k + 1) / HT) % VT) == 5) && guard < 2 * FT) begin
      run(1, 0);
      guard++;
    end
    drive(1'b0, 1'b0);
    run(2 * FT, 0);
    run(6 * FT, 4);
    run($urandom_range(50, 200), 4);
    drive(1'b0, 1'b1);
    run(3 * FT, 4);
    @(posedge clk);
    #3;
    done = 1'b1;
    checks++;
    if (eq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d want 0", eq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
